// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: ALUsel codes, FSM states and
// response flag bit positions.
package alu_seq_pkg;

  localparam logic [3:0] ALU_HOLD = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_NOT  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SHL1 = 4'b1001;
  localparam logic [3:0] ALU_PASS = 4'b1011;
  localparam logic [3:0] OP_SHLN  = 4'b1010;

  localparam int FLAGS_W    = 3;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_EQ    = 1;
  localparam int FLAG_CARRY = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    RESP  = 2'd3
  } seq_state_e;

  // Opcodes the ALU executes directly in one pass.
  function automatic logic is_single_op(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
           (op == ALU_OR)  || (op == ALU_NOT) || (op == ALU_XOR) ||
           (op == ALU_SHL1) || (op == ALU_PASS);
  endfunction

endpackage

// File: rtl/alu_seq_perf.sv
// Performance counters for alu_op_sequencer; instantiated only when
// ALU_OP_SEQUENCER_PERF_EN is defined. All counters wrap.
module alu_seq_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rsp_done,
  input  logic        i_busy,
  input  logic        i_err_done,
  output logic [31:0] o_perf_cmds,
  output logic [31:0] o_perf_busy,
  output logic [15:0] o_perf_err
);

  logic [31:0] r_cmds;
  logic [31:0] r_busy;
  logic [15:0] r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmds <= '0;
      r_busy <= '0;
      r_err  <= '0;
    end else begin
      if (i_rsp_done) r_cmds <= r_cmds + 32'd1;
      if (i_busy)     r_busy <= r_busy + 32'd1;
      if (i_err_done) r_err  <= r_err + 16'd1;
    end
  end

  assign o_perf_cmds = r_cmds;
  assign o_perf_busy = r_busy;
  assign o_perf_err  = r_err;

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side master for the 32-bit ALU: single-pass ops, sequenced variable left
// shift and a valid/ready response channel. Optional counters: ALU_OP_SEQUENCER_PERF_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic [SHAMT_W-1:0] cmd_shamt,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_sel,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_overflow,
  input  logic               alu_equal,
  input  logic               alu_carry,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic [FLAGS_W-1:0] rsp_flags,
  output logic               rsp_err
`ifdef ALU_OP_SEQUENCER_PERF_EN
  ,
  output logic [31:0]        perf_cmds,
  output logic [31:0]        perf_busy,
  output logic [15:0]        perf_err
`endif
);

  seq_state_e         r_state;
  seq_state_e         w_state_nxt;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_acc;  // latched A, reused as the shift accumulator
  logic [WIDTH-1:0]   r_b;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_rsp_result;
  logic [FLAGS_W-1:0] r_rsp_flags;
  logic               r_rsp_err;

  logic               w_accept;
  logic               w_is_shln;
  logic               w_illegal;
  logic               w_last_shift;
  logic [FLAGS_W-1:0] w_alu_flags;

  assign cmd_ready    = rst_n && (r_state == IDLE);
  assign rsp_valid    = (r_state == RESP);
  assign rsp_result   = r_rsp_result;
  assign rsp_flags    = r_rsp_flags;
  assign rsp_err      = r_rsp_err;

  assign w_accept     = cmd_valid && cmd_ready;
  assign w_is_shln    = (cmd_op == OP_SHLN);
  assign w_illegal    = !is_single_op(cmd_op) && !w_is_shln;
  assign w_last_shift = (r_cnt == SHAMT_W'(1));

  always_comb begin
    w_alu_flags             = '0;
    w_alu_flags[FLAG_OVF]   = alu_overflow;
    w_alu_flags[FLAG_EQ]    = alu_equal;
    w_alu_flags[FLAG_CARRY] = alu_carry;
  end

  always_comb begin
    w_state_nxt = r_state;
    alu_a       = '0;
    alu_b       = '0;
    alu_sel     = ALU_HOLD;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_illegal)
            w_state_nxt = RESP;
          else if (w_is_shln && (cmd_shamt != '0))
            w_state_nxt = SHIFT;
          else
            w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        alu_a       = r_acc;
        alu_b       = r_b;
        alu_sel     = (r_op == OP_SHLN) ? ALU_PASS : r_op;
        w_state_nxt = RESP;
      end
      SHIFT: begin
        alu_a   = r_acc;
        alu_sel = ALU_SHL1;
        if (w_last_shift) w_state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_op         <= ALU_HOLD;
      r_acc        <= '0;
      r_b          <= '0;
      r_cnt        <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op      <= cmd_op;
            r_acc     <= cmd_a;
            r_b       <= cmd_b;
            r_cnt     <= cmd_shamt;
            r_rsp_err <= w_illegal;
            // Illegal ops never reach the ALU, so the response is built here.
            if (w_illegal) begin
              r_rsp_result <= '0;
              r_rsp_flags  <= '0;
            end
          end
        end
        EXEC: begin
          r_rsp_result <= alu_result;
          r_rsp_flags  <= w_alu_flags;
        end
        SHIFT: begin
          r_acc <= alu_result;
          r_cnt <= r_cnt - SHAMT_W'(1);
          if (w_last_shift) begin
            r_rsp_result <= alu_result;
            r_rsp_flags  <= w_alu_flags;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_OP_SEQUENCER_PERF_EN
  logic w_rsp_done;
  logic w_busy;
  logic w_err_done;

  assign w_rsp_done = rsp_valid && rsp_ready;
  assign w_busy     = (r_state == EXEC) || (r_state == SHIFT);
  assign w_err_done = w_rsp_done && r_rsp_err;

  alu_seq_perf u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rsp_done  (w_rsp_done),
    .i_busy      (w_busy),
    .i_err_done  (w_err_done),
    .o_perf_cmds (perf_cmds),
    .o_perf_busy (perf_busy),
    .o_perf_err  (perf_err)
  );
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU attached; also
// checks the counters when ALU_OP_SEQUENCER_PERF_EN is defined.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'h0;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic [4:0]  cmd_shamt = '0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_sel;
  logic        alu_overflow, alu_equal, alu_carry;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic        rsp_err;
`ifdef ALU_OP_SEQUENCER_PERF_EN
  logic [31:0] perf_cmds, perf_busy;
  logic [15:0] perf_err;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_cmds = 0;
  int exp_busy = 0;
  int exp_errs = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_equal(alu_equal), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err)
`ifdef ALU_OP_SEQUENCER_PERF_EN
    , .perf_cmds(perf_cmds), .perf_busy(perf_busy), .perf_err(perf_err)
`endif
  );

  // Behavioural ALU: returns {overflow, equal, carry, result}.
  function automatic logic [34:0] alu_fn(input logic [3:0] sel, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic ov, c;
    r = '0; ov = 1'b0; c = 1'b0;
    case (sel)
      ALU_ADD: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      ALU_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_NOT:  r = ~a;
      ALU_XOR:  r = a ^ b;
      ALU_SHL1: begin r = a << 1; c = a[31]; ov = a[31] ^ a[30]; end
      ALU_PASS: r = a;
      default:  r = '0;
    endcase
    return {ov, (a == b), c, r};
  endfunction

  always_comb {alu_overflow, alu_equal, alu_carry, alu_result} = alu_fn(alu_sel, alu_a, alu_b);

  function automatic logic legal_op(input logic [3:0] op);
    return op inside {4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
  endfunction

  // Reference: result by plain arithmetic; flags are what the ALU reports on its last pass.
  task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, output logic [31:0] res,
                           output logic [2:0] flags, output logic err, output int lat);
    logic [34:0] r;
    err = 1'b0; res = '0; flags = '0; lat = 2;
    if (!legal_op(op)) begin
      err = 1'b1; lat = 1;
    end else if (op == OP_SHLN) begin
      res = a << sh;
      if (sh == 0) r = alu_fn(ALU_PASS, a, b);
      else begin
        r = alu_fn(ALU_SHL1, a << (sh - 1), 32'h0);
        lat = int'(sh) + 1;
      end
      flags = r[34:32];
    end else begin
      r = alu_fn(op, a, b);
      res = r[31:0]; flags = r[34:32];
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input int hold, input logic [31:0] e_res,
                         input logic [2:0] e_flags, input logic e_err, input int e_lat);
    int lat, nz, e_nz, ready_bad, opnd_bad;
    logic [3:0] last_sel, e_sel;
    logic shift_seq;
    logic [31:0] held_res;
    shift_seq = (op == OP_SHLN) && (sh != 0);
    if (!legal_op(op)) begin e_nz = 0; e_sel = ALU_HOLD; end
    else if (shift_seq) begin e_nz = int'(sh); e_sel = ALU_SHL1; end
    else if (op == OP_SHLN) begin e_nz = 1; e_sel = ALU_PASS; end
    else begin e_nz = 1; e_sel = op; end

    @(negedge clk);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_shamt = sh; cmd_valid = 1'b1;
    rsp_ready = (hold == 0);
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1; nz = 0; ready_bad = 0; opnd_bad = 0; last_sel = ALU_HOLD;
    while (!rsp_valid && lat <= 80) begin
      if (cmd_ready) ready_bad++;
      if (alu_sel != ALU_HOLD) begin
        last_sel = alu_sel;
        if (shift_seq) begin
          if (alu_a != (a << nz) || alu_b != 32'h0) opnd_bad++;
        end else if (alu_a != a || alu_b != b) opnd_bad++;
        nz++;
      end
      @(negedge clk);
      lat++;
    end
    chk("rsp_valid_seen", rsp_valid, 1);
    chk("latency", lat, e_lat);
    chk("result", rsp_result, e_res);
    chk("flags", rsp_flags, e_flags);
    chk("err", rsp_err, e_err);
    chk("alu_active_cycles", nz, e_nz);
    chk("alu_sel_issued", last_sel, e_sel);
    chk("alu_operands_bad", opnd_bad, 0);
    chk("cmd_ready_busy", ready_bad, 0);
    chk("alu_sel_in_resp", alu_sel, ALU_HOLD);
    exp_cmds++; exp_busy += e_nz; exp_errs += int'(e_err);
    held_res = rsp_result;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_result", rsp_result, held_res);
      chk("hold_flags", rsp_flags, e_flags);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_drop", rsp_valid, 0);
    chk("cmd_ready_after", cmd_ready, 1);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    int          hold;
    logic [31:0] res;
    logic [2:0]  flags;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b, e_res;
    logic [4:0]  r_sh;
    logic [2:0]  e_flags;
    logic        e_err;
    int          e_lat, accepts, resps, quiet_bad;

    vecs[0]  = '{4'h1, 32'h5,         32'h3,         5'd0,  0, 32'h8,         3'b000, 1'b0, 2};
    vecs[1]  = '{4'hA, 32'h1,         32'h0,         5'd4,  0, 32'h10,        3'b000, 1'b0, 5};
    vecs[2]  = '{4'hA, 32'h1234,      32'h1234,      5'd0,  0, 32'h1234,      3'b010, 1'b0, 2};
    vecs[3]  = '{4'h3, 32'hDEAD,      32'hBEEF,      5'd0,  0, 32'h0,         3'b000, 1'b1, 1};
    vecs[4]  = '{4'h2, 32'd10,        32'd3,         5'd0,  5, 32'd7,         3'b001, 1'b0, 2};
    vecs[5]  = '{4'h8, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0,  0, 32'hF0F0_0F0F, 3'b000, 1'b0, 2};
    vecs[6]  = '{4'h5, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0,  0, 32'h0F00_0F00, 3'b000, 1'b0, 2};
    vecs[7]  = '{4'h6, 32'h00F0,      32'h0F00,      5'd0,  0, 32'h0FF0,      3'b000, 1'b0, 2};
    vecs[8]  = '{4'h7, 32'h0,         32'h0,         5'd0,  0, 32'hFFFF_FFFF, 3'b010, 1'b0, 2};
    vecs[9]  = '{4'h1, 32'h7FFF_FFFF, 32'h1,         5'd0,  0, 32'h8000_0000, 3'b100, 1'b0, 2};
    vecs[10] = '{4'h1, 32'hFFFF_FFFF, 32'h1,         5'd0,  0, 32'h0,         3'b001, 1'b0, 2};
    vecs[11] = '{4'hA, 32'h8000_0001, 32'h5,         5'd1,  0, 32'h2,         3'b101, 1'b0, 2};
    vecs[12] = '{4'hA, 32'hF,         32'h0,         5'd31, 0, 32'h8000_0000, 3'b001, 1'b0, 32};
    vecs[13] = '{4'h0, 32'h1,         32'h1,         5'd0,  2, 32'h0,         3'b000, 1'b1, 1};
    vecs[14] = '{4'h9, 32'hC000_0000, 32'hC000_0000, 5'd0,  0, 32'h8000_0000, 3'b011, 1'b0, 2};
    vecs[15] = '{4'hB, 32'hABCD,      32'h0,         5'd0,  0, 32'hABCD,      3'b000, 1'b0, 2};
    vecs[16] = '{4'hF, 32'h55,        32'h66,        5'd3,  1, 32'h0,         3'b000, 1'b1, 1};

    // Reset state.
    #12;
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_rsp_flags", rsp_flags, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_alu_sel", alu_sel, 0);
    chk("reset_alu_ab", {alu_a, alu_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("cmd_ready_after_release", cmd_ready, 1);

    foreach (vecs[i])
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].hold,
              vecs[i].res, vecs[i].flags, vecs[i].err, vecs[i].lat);

    // Reset in the middle of a long shift.
    @(negedge clk);
    cmd_op = OP_SHLN; cmd_a = 32'h1; cmd_b = 32'h0; cmd_shamt = 5'd20; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_shift_sel", alu_sel, ALU_SHL1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_alu_sel", alu_sel, 0);
    chk("midrst_alu_ab", {alu_a, alu_b}, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_rsp_result", rsp_result, 0);
    chk("midrst_rsp_flags_err", {rsp_flags, rsp_err}, 0);
    exp_cmds = 0; exp_busy = 0; exp_errs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    quiet_bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) quiet_bad++;
    end
    chk("no_rsp_after_reset", quiet_bad, 0);
    run_cmd(ALU_ADD, 32'd100, 32'd23, 5'd0, 0, 32'd123, 3'b000, 1'b0, 2);

    // Back-to-back XOR with cmd_valid held high.
    @(negedge clk);
    cmd_op = ALU_XOR; cmd_a = 32'hFFFF_0000; cmd_b = 32'h0F0F_0F0F; cmd_shamt = 5'd0;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    accepts = 0; resps = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 23) cmd_valid = 1'b0;
      if (cmd_valid && cmd_ready) accepts++;
      if (rsp_valid) begin
        resps++;
        chk("b2b_result", rsp_result, 32'hF0F0_0F0F);
`ifdef ALU_OP_SEQUENCER_PERF_EN
        chk("b2b_perf_cmds", perf_cmds, exp_cmds);
`endif
        exp_cmds++;
      end
      @(negedge clk);
    end
    repeat (4) begin
      if (rsp_valid) begin
        resps++;
        chk("b2b_result", rsp_result, 32'hF0F0_0F0F);
        exp_cmds++;
      end
      @(negedge clk);
    end
    exp_busy += accepts;
    chk("b2b_accepts", accepts, 8);
    chk("b2b_resp_count", resps, accepts);

    // Randomized commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
      r_sh = 5'($urandom_range(0, 31));
      ref_model(r_op, r_a, r_b, r_sh, e_res, e_flags, e_err, e_lat);
      run_cmd(r_op, r_a, r_b, r_sh, $urandom_range(0, 3), e_res, e_flags, e_err, e_lat);
    end

`ifdef ALU_OP_SEQUENCER_PERF_EN
    chk("perf_cmds", perf_cmds, exp_cmds);
    chk("perf_busy", perf_busy, exp_busy);
    chk("perf_err", perf_err, exp_errs);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
